multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
//  Moore FSM sequencing the shared multicycle MIPS datapath (one memory, one ALU) over IDLE/FETCH/DECODE/EXEC/MEM/WB.
//  Drives the strobes consumed by the ALUControl and register-file blocks; ALUOp encoding is the datapath's existing one.
//  Waits on a variable-latency memory via a MemReady handshake, traps on illegal opcode or memory timeout.
//  Counts retired instructions for debug.
// PARAMETERS
//  MEM_TIMEOUT  15  max wait cycles for MemReady before TRAP (1..255)
//  CNT_W        32  width of InstrCount
// PORTS
//  Clk          in   1      clock, rising edge
//  Rst          in   1      asynchronous, active-low reset
//  Opcode       in   6      IR[31:26]; stable from DECODE until the next FETCH
//  Funct        in   6      IR[5:0]; R-type only
//  Zero         in   1      ALU zero flag, valid in BRANCH
//  MemReady     in   1      memory completes the current read/write this cycle
//  MemRead      out  1      memory read strobe, held until MemReady
//  MemWrite     out  1      memory write strobe, held until MemReady
//  IorD         out  1      0: address=PC, 1: address=ALUOut
//  IRWrite      out  1      load IR (FETCH & MemReady)
//  PCWrite      out  1      load PC (final; includes branch condition)
//  PCSrc        out  2      00 ALU(PC+4), 01 ALUOut(branch target), 10 jump target
//  ALUSrcA      out  1      0: PC, 1: rs
//  ALUSrcB      out  2      00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  ALUOp        out  2      00 R-type(funct), 01 add (addi/lw/sw), 10 subtract (beq/bne), 11 unused
//  RegDst       out  1      1: rd, 0: rt
//  MemtoReg     out  1      1: MDR, 0: ALUOut
//  RegWrite     out  1      register-file write enable
//  InstrDone    out  1      one-cycle pulse in the last state of each instruction
//  InstrCount   out  CNT_W  retired instruction count, wraps
//  Debug        out  1      high while in TRAP
// BEHAVIOUR
//  - Reset (Rst=0, any time): state<=IDLE, timer<=0, InstrCount<=0 immediately; all outputs 0 while Rst=0 and in IDLE.
//  - IDLE -> FETCH unconditionally (one cycle after reset release).
//  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=01, PCSrc=00. Stay until MemReady;
//    in the MemReady cycle IRWrite=1 and PCWrite=1, then -> DECODE.
//  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=01 (branch target into ALUOut). Next by Opcode:
//    000000 -> RTEXEC; 100011/101011 -> MEMADR; 001000 -> ADDIEXEC; 000100/000101 -> BRANCH; 000010 -> JUMP; else -> TRAP.
//  - RTEXEC (ALUSrcA=1,ALUSrcB=00,ALUOp=00) -> RTWB (RegDst=1,MemtoReg=0,RegWrite=1,InstrDone).
//  - ADDIEXEC (ALUSrcA=1,ALUSrcB=10,ALUOp=01) -> ADDIWB (RegDst=0,MemtoReg=0,RegWrite=1,InstrDone).
//  - MEMADR (ALUSrcA=1,ALUSrcB=10,ALUOp=01) -> MEMRD (lw) or MEMWR (sw).
//  - MEMRD: MemRead=1,IorD=1; wait MemReady -> MEMWB (RegDst=0,MemtoReg=1,RegWrite=1,InstrDone).
//  - MEMWR: MemWrite=1,IorD=1; wait MemReady; InstrDone in the MemReady cycle.
//  - BRANCH: ALUSrcA=1,ALUSrcB=00,ALUOp=10,PCSrc=01; PCWrite=Zero (beq) or ~Zero (bne); InstrDone.
//  - JUMP: PCSrc=10, PCWrite=1, InstrDone.
//  - All InstrDone states -> FETCH. InstrCount increments on InstrDone, wraps 2^CNT_W-1 -> 0.
//  - Latency with zero-wait memory: R/addi 4, lw 5, sw 4, beq/bne/j 3 cycles.
//  - Timer: cleared on entry to FETCH/MEMRD/MEMWR, +1 per waiting cycle with MemReady=0.
//    MemReady has priority: ready on the cycle the timer reaches MEM_TIMEOUT is success.
//    Timer==MEM_TIMEOUT and MemReady=0 -> TRAP; the strobe drops next cycle.
//  - TRAP: Debug=1, all other strobes 0, no InstrDone, no exit except reset.
//  - MemRead and MemWrite are never both 1; RegWrite/PCWrite never 1 in IDLE/TRAP.
// STRUCTURE
//  - Shared header mips_defs.vh: opcode constants, state encodings (4-bit), ALUOp/PCSrc/ALUSrcB codes.
//  - Sub-module mem_wait_timer (clear, inc, expired) for the timeout counter; rest is one FSM plus output decode.
// TESTING
//  - Reset then add (Opcode 0, Funct 100000), MemReady=1 -> ALUOp 00 in RTEXEC, RegWrite+RegDst=1 at cycle 4, InstrCount=1.
//  - lw (100011), MemReady low 3 cycles in MEMRD -> MemRead held 4 cycles, MemtoReg=1 RegWrite=1 next cycle, total 8.
//  - beq Zero=1 then Zero=0; bne Zero=0 -> PCWrite=1,0,1 in BRANCH with PCSrc=01, ALUOp=10.
//  - sw with MemReady never asserted, MEM_TIMEOUT=15 -> TRAP after 15 wait cycles, Debug=1, MemWrite=0.
//  - MemReady on exactly the 15th wait cycle -> no TRAP; illegal opcode 111111 -> TRAP with no InstrDone.
//  - Rst low mid-MEMRD -> outputs 0 immediately, InstrCount=0; after release IDLE then FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: shared opcode, state and datapath-select encodings
//   state_t      : 4-bit FSM state encoding
//   OP_*         : IR[31:26] opcodes understood by the sequencer
//   ALUOP_*      : ALUOp codes consumed by ALUControl
//   PCSRC_*      : PC source mux selects
//   ALUB_*       : ALU B-operand mux selects
//   decode_next  : DECODE-state dispatch by opcode
package multicycle_control_fsm_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_RTEXEC, S_RTWB, S_ADDIEXEC, S_ADDIWB,
    S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_TRAP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_ADD   = 2'b01;
  localparam logic [1:0] ALUOP_SUB   = 2'b10;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;
  function automatic state_t decode_next(input logic [5:0] op);
    return (op == OP_RTYPE)                ? S_RTEXEC   :
           (op == OP_LW   || op == OP_SW)  ? S_MEMADR   :
           (op == OP_ADDI)                 ? S_ADDIEXEC :
           (op == OP_BEQ  || op == OP_BNE) ? S_BRANCH   :
           (op == OP_J)                    ? S_JUMP     : S_TRAP;
  endfunction
endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// multicycle_control_fsm_mem_wait_timer: counts memory wait cycles and flags timeout
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : zero the count (takes priority over i_inc)
//   i_inc          : count one more wait cycle
//   o_expired      : count has reached LIMIT
module multicycle_control_fsm_mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);
  logic [7:0] r_count;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_inc) r_count <= r_count + 8'd1;
  assign o_expired = r_count == 8'(LIMIT);
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequencer for the shared-memory multicycle MIPS datapath
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_opcode, i_funct   : IR[31:26], IR[5:0]
//   i_zero              : ALU zero flag (branch)
//   i_mem_ready         : memory completes the current access
//   o_mem_read/write    : memory strobes, held until ready
//   o_iord              : 0 address=PC, 1 address=ALUOut
//   o_ir_write, o_pc_write, o_pc_src : IR/PC load controls
//   o_alu_src_a/b, o_alu_op          : ALU operand/opcode selects
//   o_reg_dst, o_mem_to_reg, o_reg_write : register-file controls
//   o_instr_done, o_instr_count      : retire pulse and wrapping count
//   o_debug             : high while trapped
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [5:0]       i_opcode,
  input  logic [5:0]       i_funct,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_iord,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic [1:0]       o_pc_src,
  output logic             o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic             o_reg_dst,
  output logic             o_mem_to_reg,
  output logic             o_reg_write,
  output logic             o_instr_done,
  output logic [CNT_W-1:0] o_instr_count,
  output logic             o_debug
);
  state_t           r_state;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_waiting;
  logic             w_expired;
  logic             w_unused_funct;
  // funct is decoded by ALUControl, not here
  assign w_unused_funct = ^i_funct;
  assign w_waiting = r_state inside {S_FETCH, S_MEMRD, S_MEMWR};
  // a ready cycle always leaves the wait state, so clearing on it doubles as clear-on-entry
  multicycle_control_fsm_mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (!w_waiting || i_mem_ready),
    .i_inc     (w_waiting && !i_mem_ready),
    .o_expired (w_expired)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_instr_count <= '0;
    end else begin
      if (o_instr_done) r_instr_count <= r_instr_count + 1'b1;
      case (r_state)
        S_IDLE:     r_state <= S_FETCH;
        S_FETCH:    r_state <= i_mem_ready ? S_DECODE : w_expired ? S_TRAP : S_FETCH;
        S_DECODE:   r_state <= decode_next(i_opcode);
        S_RTEXEC:   r_state <= S_RTWB;
        S_ADDIEXEC: r_state <= S_ADDIWB;
        S_MEMADR:   r_state <= (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:    r_state <= i_mem_ready ? S_MEMWB : w_expired ? S_TRAP : S_MEMRD;
        S_MEMWR:    r_state <= i_mem_ready ? S_FETCH : w_expired ? S_TRAP : S_MEMWR;
        S_RTWB, S_ADDIWB, S_MEMWB, S_BRANCH, S_JUMP: r_state <= S_FETCH;
        S_TRAP:     r_state <= S_TRAP;
        default:    r_state <= S_IDLE;
      endcase
    end
  always_comb begin
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_iord       = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = PCSRC_ALU;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = ALUB_RT;
    o_alu_op     = ALUOP_RTYPE;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_write  = 1'b0;
    o_instr_done = 1'b0;
    o_debug      = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = ALUB_FOUR;
        o_alu_op    = ALUOP_ADD;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_alu_src_b = ALUB_IMM_SH;
        o_alu_op    = ALUOP_ADD;
      end
      S_RTEXEC: o_alu_src_a = 1'b1;
      S_RTWB: begin
        o_reg_dst    = 1'b1;
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
      end
      S_ADDIEXEC, S_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = ALUB_IMM;
        o_alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
      end
      S_MEMRD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      S_MEMWB: begin
        o_mem_to_reg = 1'b1;
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_mem_write  = 1'b1;
        o_iord       = 1'b1;
        o_instr_done = i_mem_ready;
      end
      S_BRANCH: begin
        o_alu_src_a  = 1'b1;
        o_alu_op     = ALUOP_SUB;
        o_pc_src     = PCSRC_ALUOUT;
        o_pc_write   = (i_opcode == OP_BNE) ? !i_zero : i_zero;
        o_instr_done = 1'b1;
      end
      S_JUMP: begin
        o_pc_src     = PCSRC_JUMP;
        o_pc_write   = 1'b1;
        o_instr_done = 1'b1;
      end
      S_TRAP: o_debug = 1'b1;
      default: ;
    endcase
  end
  assign o_instr_count = r_instr_count;
endmodule
